// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-side memory path: word-address geometry and
// the store-buffer entry layout.
package mips_mem_pkg;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int BYTE_OFS = 2;
    localparam int WORD_AW  = AW - BYTE_OFS;

    typedef struct packed {
        logic [WORD_AW-1:0] wadr;
        logic [DW-1:0]      data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// DEPTH-way word-address comparator; the youngest valid match supplies the
// forwarded data.
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PW-1:0]      tail,
    input  logic [WORD_AW-1:0] lookup,
    output logic               hit,
    output logic [DW-1:0]      data
);

    logic [PW-1:0] idx;

    // Walk from tail (oldest slot) towards the youngest so later matches
    // overwrite earlier ones.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail + PW'(k);
            if (valid[idx] && entries[idx].wadr == lookup) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory, with
// youngest-match forwarding of buffered stores to loads.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_memwrite,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head, tail;
    logic             push, pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign mem_we    = !empty;
    assign pop       = mem_we & mem_ready;
    assign push      = cpu_memwrite & (!full | pop);
    assign cpu_stall = cpu_memwrite & full & !pop;
    assign mem_adr   = empty ? '0 : {entries[head].wadr, BYTE_OFS'(0)};
    assign mem_wdata = empty ? '0 : entries[head].data;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop)  head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            // At full with push and pop, head == tail; the push must win.
            if (pop)  valid[head] <= 1'b0;
            if (push) valid[tail] <= 1'b1;
        end
    end

    // NOTE: the entry array is not reset; valid bits and count gate every read of it.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= '{wadr: cpu_adr[AW-1:BYTE_OFS], data: cpu_wdata};
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries (entries),
        .valid   (valid),
        .tail    (tail),
        .lookup  (cpu_adr[AW-1:BYTE_OFS]),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_store_buffer;

    logic        clk, reset;
    logic        cpu_memwrite, cpu_stall, fwd_hit, mem_we, mem_ready, empty, full;
    logic [31:0] cpu_adr, cpu_wdata, fwd_data, mem_adr, mem_wdata;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic [29:0] q_adr [$];
    logic [31:0] q_dat [$];

    store_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memwrite (cpu_memwrite),
        .cpu_adr      (cpu_adr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at edge+1, compare at mid-cycle, update model after the edge.
    task automatic cycle(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                         input logic rdy, output logic acc);
        logic        e_we, e_pop, e_full, e_stall, e_push, e_hit;
        logic [31:0] e_adr, e_wd, e_fd;
        int          n;
        cpu_memwrite = wr;
        cpu_adr      = adr;
        cpu_wdata    = wd;
        mem_ready    = rdy;
        #4;
        n       = q_adr.size();
        e_we    = (n != 0);
        e_adr   = e_we ? {q_adr[0], 2'b00} : 32'h0;
        e_wd    = e_we ? q_dat[0] : 32'h0;
        e_pop   = e_we && rdy;
        e_full  = (n == 4);
        e_stall = wr && e_full && !e_pop;
        e_push  = wr && !e_stall;
        e_hit   = 1'b0;
        e_fd    = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (q_adr[i] == adr[31:2]) begin
                e_hit = 1'b1;
                e_fd  = q_dat[i];
            end
        end
        check("mem_we",    {31'b0, mem_we},    {31'b0, e_we});
        check("mem_adr",   mem_adr,            e_adr);
        check("mem_wdata", mem_wdata,          e_wd);
        check("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
        check("fwd_hit",   {31'b0, fwd_hit},   {31'b0, e_hit});
        check("fwd_data",  fwd_data,           e_fd);
        check("count",     {29'b0, count},     n);
        check("count_le4", {31'b0, count <= 3'd4}, 32'd1);
        check("empty",     {31'b0, empty},     {31'b0, n == 0});
        check("full",      {31'b0, full},      {31'b0, e_full});
        @(posedge clk);
        #1;
        if (e_pop) begin
            void'(q_adr.pop_front());
            void'(q_dat.pop_front());
        end
        if (e_push) begin
            q_adr.push_back(adr[31:2]);
            q_dat.push_back(wd);
        end
        acc = e_push;
    endtask

    task automatic idle(input int cycles, input logic rdy);
        logic acc;
        for (int i = 0; i < cycles; i++) cycle(1'b0, 32'h0, 32'h0, rdy, acc);
    endtask

    initial begin
        logic acc;
        int   accepted, budget;
        reset        = 1'b0;
        cpu_memwrite = 1'b0;
        cpu_adr      = '0;
        cpu_wdata    = '0;
        mem_ready    = 1'b0;
        #12;
        check("rst_count", {29'b0, count}, 0);
        check("rst_empty", {31'b0, empty}, 1);
        check("rst_we",    {31'b0, mem_we}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset with stores pending
        cycle(1'b1, 32'h100, 32'hA1, 1'b0, acc);
        cycle(1'b1, 32'h104, 32'hA2, 1'b0, acc);
        cycle(1'b1, 32'h108, 32'hA3, 1'b0, acc);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_count", {29'b0, count}, 0);
        check("midrst_we",    {31'b0, mem_we}, 0);
        check("midrst_empty", {31'b0, empty}, 1);
        check("midrst_adr",   mem_adr, 0);
        q_adr.delete();
        q_dat.delete();
        cpu_memwrite = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3, 1'b1);

        // Basic drain
        cycle(1'b1, 32'h40, 32'h54, 1'b1, acc);
        check("basic_we",  {31'b0, mem_we}, 1);
        check("basic_adr", mem_adr, 32'h40);
        check("basic_dat", mem_wdata, 32'h54);
        idle(2, 1'b1);

        // Fill and stall
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 4 * i, 32'hB0 + i, 1'b0, acc);
        check("fill_full", {31'b0, full}, 1);
        cycle(1'b1, 32'h210, 32'hB4, 1'b0, acc);
        check("stall_rej", {31'b0, acc}, 0);
        cycle(1'b1, 32'h210, 32'hB4, 1'b1, acc);
        check("stall_acc", {31'b0, acc}, 1);
        check("full_cnt",  {29'b0, count}, 4);
        idle(6, 1'b1);

        // Forwarding priority
        cycle(1'b1, 32'h80, 32'h11, 1'b0, acc);
        cycle(1'b1, 32'h80, 32'h22, 1'b0, acc);
        cycle(1'b0, 32'h82, 32'h0, 1'b0, acc);
        cycle(1'b0, 32'h84, 32'h0, 1'b0, acc);
        idle(3, 1'b1);

        // Pop-cycle forward
        cycle(1'b1, 32'h10, 32'h33, 1'b1, acc);
        cycle(1'b0, 32'h10, 32'h0, 1'b1, acc);
        cycle(1'b0, 32'h10, 32'h0, 1'b1, acc);

        // Random traffic with toggling mem_ready
        accepted = 0;
        budget   = 0;
        while (accepted < 10 && budget < 200) begin
            logic        wr;
            logic [31:0] a;
            wr = ($urandom_range(0, 3) != 0);
            a  = {26'h0, 3'($urandom_range(0, 7)), 2'b00} | 32'($urandom_range(0, 3));
            cycle(wr, a, $urandom, budget[0], acc);
            if (acc) accepted++;
            budget++;
        end
        check("rand_accepted", accepted, 10);
        idle(8, 1'b1);
        check("final_empty", {31'b0, empty}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write queue between the single-cycle MIPS core's data port and the data memory.
- Absorbs stores (memwrite/dataadr/writedata) into a DEPTH-entry FIFO and drains them to memory one per cycle when the memory accepts.
- Forwards buffered store data to same-word loads so the core never reads stale memory.
- Stalls the core only when the buffer is full and cannot drain in the same cycle.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- AW, 32, byte-address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_memwrite  input  1  core requests a store this cycle.
- cpu_adr  input  AW  core byte address; used for stores and for load forwarding.
- cpu_wdata  input  DW  store data.
- cpu_stall  output  1  store not accepted; core must hold all inputs.
- fwd_hit  output  1  cpu_adr word matches a buffered entry.
- fwd_data  output  DW  data of the youngest matching entry; 0 when no hit.
- mem_we  output  1  head entry presented to memory.
- mem_adr  output  AW  head byte address; low 2 bits are 0.
- mem_wdata  output  DW  head data.
- mem_ready  input  1  memory accepts the presented write this cycle.
- count  output  $clog2(DEPTH)+1  occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (reset low, async):
  - head/tail pointers = 0, count = 0, all valid bits cleared.
  - Outputs go to cpu_stall=0, fwd_hit=0, fwd_data=0, mem_we=0, mem_adr=0, mem_wdata=0, empty=1, full=0.
  - Pending stores are discarded; reset mid-drain aborts without a further mem_we.
- Storage:
  - Each entry holds word address (adr[AW-1:2]) and data.
  - Address bits [1:0] are dropped; all accesses are word accesses.
- Drain (combinational outputs, registered state):
  - mem_we = !empty; mem_adr/mem_wdata come from the head entry.
  - pop = mem_we & mem_ready; on pop, head advances modulo DEPTH at the clock edge.
  - mem_adr and mem_wdata are 0 when empty.
- Enqueue:
  - push = cpu_memwrite & (!full | pop); on push, the entry is written at tail and tail advances modulo DEPTH.
  - cpu_stall = cpu_memwrite & full & !pop (combinational); a held store is accepted in the first cycle the condition clears.
  - No coalescing: repeated stores to one word occupy separate entries and drain in program order.
- Count: next count = count + push - pop. Simultaneous push and pop leaves count unchanged, including at full and at count == 1.
- Empty push: an entry written into an empty buffer presents on mem_we the following cycle; there is no same-cycle bypass to memory.
- Forwarding (combinational):
  - Compare cpu_adr[AW-1:2] against all valid entries; the youngest (closest to tail) match wins.
  - The entry being popped this cycle still forwards; an entry being pushed this cycle does not.
  - fwd_hit is independent of cpu_memwrite.
- Ordering: memory sees writes in exactly acceptance order; no drops or duplicates.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count, not pointer equality.

Decomposition:
- Package mips_mem_pkg holds:
  - localparams WORD_AW = AW-2, BYTE_OFS = 2;
  - typedef struct packed { logic [WORD_AW-1:0] wadr; logic [DW-1:0] data; } sb_entry_t.
- One sub-module, sb_fwd_match: DEPTH-way comparator with youngest-first priority select. Inputs are the entry array, valid vector, tail pointer and lookup word address; outputs are hit and data.

Test Plan:
- Reset with stores pending: push 3 entries with mem_ready=0, then assert reset low mid-cycle -> count=0, mem_we=0, empty=1 immediately; no write reaches memory after reset.
- Basic drain: with mem_ready=1, store 0x54→adr 0x40 -> next cycle mem_we=1, mem_adr=0x40, mem_wdata=0x54; following cycle empty=1.
- Fill and stall:
  - With mem_ready=0, push 5 stores at DEPTH=4 -> full=1 after 4; cpu_stall=1 on the 5th.
  - Raise mem_ready -> 5th accepted in that cycle, count stays 4.
  - Memory receives all 5 in order.
- Forwarding priority:
  - With mem_ready=0, store 0x11→0x80 then 0x22→0x80.
  - Load cpu_adr=0x82 -> fwd_hit=1, fwd_data=0x22.
  - Load cpu_adr=0x84 -> fwd_hit=0, fwd_data=0.
- Pop-cycle forward: single entry 0x33→0x10 with mem_ready=1 and cpu_adr=0x10 in the pop cycle -> fwd_hit=1, fwd_data=0x33; next cycle fwd_hit=0.
- Wrap-around: 10 random stores with mem_ready toggling 1/0 -> scoreboard matches memory write order; count never exceeds 4; no cpu_stall while count<4.
